// File: rtl/norm_shift_pipe_pkg.sv
// Shared constants, width helper and result record for the normalizer pipeline.
package norm_pkg;

    localparam int W_IN_DEF  = 32;
    localparam int W_EXP_DEF = 8;

    function automatic int lz_width(input int w_in);
        return $clog2(w_in);
    endfunction

    localparam int W_LZ_DEF = lz_width(W_IN_DEF);

    typedef struct packed {
        logic [W_IN_DEF-1:0]  data;
        logic [W_EXP_DEF-1:0] exp;
        logic [W_LZ_DEF-1:0]  shift;
        logic                 zero;
        logic                 denorm;
    } norm_res_t;

endpackage

// File: rtl/norm_shift_pipe_if.sv
// Upstream and downstream valid/ready bundle of the normalizer.
interface norm_shift_pipe_if
    import norm_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int W_EXP = W_EXP_DEF
) ();
    localparam int W_LZ = lz_width(W_IN);

    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_data;
    logic [W_EXP-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [W_IN-1:0]  out_data;
    logic [W_EXP-1:0] out_exp;
    logic [W_LZ-1:0]  out_shift;
    logic             out_zero;
    logic             out_denorm;

    modport slave (
        input  in_valid, in_data, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_shift, out_zero, out_denorm
    );

    modport master (
        output in_valid, in_data, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_shift, out_zero, out_denorm
    );
endinterface

// File: rtl/norm_shift_pipe_clz.sv
// Combinational leading-zero counter; an all-zero word yields the all-ones count.
module CountLeadingZeros #(
    parameter int W = 32
) (
    input  logic [W-1:0]         i_data,
    output logic [$clog2(W)-1:0] o_count
);
    localparam int W_C = $clog2(W);

    logic w_found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        o_count = '1;
        w_found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_count = W_C'(W - 1 - i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end
endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: stage 1 holds the raw word, stage 2 holds the shifted result.
module norm_shift_pipe
    import norm_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int W_EXP = W_EXP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    norm_shift_pipe_if.slave  bus
);
    localparam int W_LZ = lz_width(W_IN);

    typedef struct packed {
        logic [W_IN-1:0]  data;
        logic [W_EXP-1:0] exp;
        logic [W_LZ-1:0]  shift;
        logic             zero;
        logic             denorm;
    } res_t;

    generate
        if (W_EXP < W_LZ) begin : g_bad_width
            $error("norm_shift_pipe: W_EXP must be at least W_LZ");
        end
    endgenerate

    logic             r_s1_valid;
    logic [W_IN-1:0]  r_s1_data;
    logic [W_EXP-1:0] r_s1_exp;
    logic             r_s2_valid;
    res_t             r_res;

    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [W_LZ-1:0]  w_lz;
    logic [W_EXP-1:0] w_lz_ext;
    logic [W_LZ-1:0]  w_shift;
    res_t             w_res;

    assign w_s1_adv   = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    CountLeadingZeros #(.W(W_IN)) u_clz (
        .i_data  (r_s1_data),
        .o_count (w_lz)
    );

    // Exponent clamp: when the exponent runs out first, shift only by the exponent
    // and flag a denormal. In that case exp < lz < W_IN so the low bits hold it exactly.
    always_comb begin
        w_lz_ext = W_EXP'(w_lz);
        w_shift  = '0;
        w_res    = '0;
        if (r_s1_data == '0) begin
            w_res.zero = 1'b1;
        end else if (r_s1_exp >= w_lz_ext) begin
            w_shift    = w_lz;
            w_res.exp  = r_s1_exp - w_lz_ext;
            w_res.data = r_s1_data << w_shift;
            w_res.shift = w_shift;
        end else begin
            w_shift      = r_s1_exp[W_LZ-1:0];
            w_res.denorm = 1'b1;
            w_res.data   = r_s1_data << w_shift;
            w_res.shift  = w_shift;
        end
    end

    // Stage 1: capture on input transfer, empty when its word moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_exp   <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= bus.in_data;
            r_s1_exp   <= bus.in_exp;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: the output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_res;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_data   = r_res.data;
    assign bus.out_exp    = r_res.exp;
    assign bus.out_shift  = r_res.shift;
    assign bus.out_zero   = r_res.zero;
    assign bus.out_denorm = r_res.denorm;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe: directed vectors, backpressure, random traffic, reset.
module tb_norm_shift_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  exp;
        logic [4:0]  shift;
        logic        zero;
        logic        denorm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_out;
    bit   mon_en;
    exp_t sb[$];

    norm_shift_pipe_if #(.W_IN(32), .W_EXP(8)) bus ();

    norm_shift_pipe #(.W_IN(32), .W_EXP(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] d, input logic [7:0] e);
        exp_t        r;
        int          lz;
        logic [31:0] t;
        r = '0;
        if (d == 32'd0) begin
            r.zero = 1'b1;
            return r;
        end
        t  = d;
        lz = 0;
        while (t[31] == 1'b0) begin
            t  = t << 1;
            lz = lz + 1;
        end
        if (int'(e) >= lz) begin
            r.shift = 5'(lz);
            r.exp   = e - 8'(lz);
        end else begin
            r.shift  = e[4:0];
            r.exp    = 8'd0;
            r.denorm = 1'b1;
        end
        r.data = d << r.shift;
        return r;
    endfunction

    // Output monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            exp_t got;
            exp_t want;
            got = {bus.out_data, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_denorm};
            n_checks = n_checks + 1;
            n_out    = n_out + 1;
            if (sb.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL unexpected_output got data=%h exp=%0d shift=%0d zero=%0d denorm=%0d, expected none",
                         got.data, got.exp, got.shift, got.zero, got.denorm);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_errors = n_errors + 1;
                    $display("FAIL result got data=%h exp=%0d shift=%0d zero=%0d denorm=%0d, expected data=%h exp=%0d shift=%0d zero=%0d denorm=%0d",
                             got.data, got.exp, got.shift, got.zero, got.denorm,
                             want.data, want.exp, want.shift, want.zero, want.denorm);
                end
            end
        end
    end

    // Present one word until accepted; the expected result is queued at acceptance.
    task automatic drive(input logic [31:0] d, input logic [7:0] e, input exp_t x);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_exp   = e;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(x);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        n_checks = n_checks + 1;
        if (!ok) begin
            n_errors = n_errors + 1;
            $display("FAIL drive_timeout in_ready stayed 0 for data=%h, expected acceptance", d);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL drain_timeout %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks = n_checks + 1;
        if ({bus.out_valid, bus.out_data, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_denorm} !== 48'd0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_outputs got valid=%0d data=%h exp=%0d shift=%0d, expected all 0",
                     bus.out_valid, bus.out_data, bus.out_exp, bus.out_shift);
        end
        n_checks = n_checks + 1;
        if (bus.in_ready !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_in_ready got %b, expected 1", bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed vectors with a latency check on each.
    task automatic test_basic();
        logic [31:0] d[4];
        logic [7:0]  e[4];
        exp_t        x[4];
        d[0] = 32'h0001_0000; e[0] = 8'd100; x[0] = {32'h8000_0000, 8'd85, 5'd15, 1'b0, 1'b0};
        d[1] = 32'h8000_0000; e[1] = 8'd5;   x[1] = {32'h8000_0000, 8'd5,  5'd0,  1'b0, 1'b0};
        d[2] = 32'h0000_0001; e[2] = 8'd10;  x[2] = {32'h0000_0400, 8'd0,  5'd10, 1'b0, 1'b1};
        d[3] = 32'h0000_0000; e[3] = 8'd77;  x[3] = {32'h0000_0000, 8'd0,  5'd0,  1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(d[i], e[i], x[i]);
            @(negedge clk);
            n_checks = n_checks + 1;
            if (bus.out_valid !== 1'b0) begin
                n_errors = n_errors + 1;
                $display("FAIL latency_early vec%0d out_valid=%b one cycle after transfer, expected 0", i, bus.out_valid);
            end
            @(negedge clk);
            n_checks = n_checks + 1;
            if (bus.out_valid !== 1'b1) begin
                n_errors = n_errors + 1;
                $display("FAIL latency vec%0d out_valid=%b two cycles after transfer, expected 1", i, bus.out_valid);
            end
            wait_drain();
        end
    endtask

    task automatic test_backpressure();
        bit got3;
        bus.out_ready = 1'b0;
        drive(32'h1, 8'd40, model(32'h1, 8'd40));
        drive(32'h2, 8'd40, model(32'h2, 8'd40));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4;
        bus.in_exp   = 8'd40;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks = n_checks + 1;
            if (bus.in_ready !== 1'b0) begin
                n_errors = n_errors + 1;
                $display("FAIL bp_in_ready stall%0d got %b, expected 0", c, bus.in_ready);
            end
            n_checks = n_checks + 1;
            if ({bus.out_valid, bus.out_data, bus.out_exp, bus.out_shift} !== {1'b1, 32'h8000_0000, 8'd9, 5'd31}) begin
                n_errors = n_errors + 1;
                $display("FAIL bp_hold stall%0d got valid=%b data=%h exp=%0d shift=%0d, expected valid=1 data=80000000 exp=9 shift=31",
                         c, bus.out_valid, bus.out_data, bus.out_exp, bus.out_shift);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        got3 = 1'b0;
        for (int c = 0; c < 10 && !got3; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(model(32'h4, 8'd40));
                got3 = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        n_checks = n_checks + 1;
        if (!got3) begin
            n_errors = n_errors + 1;
            $display("FAIL bp_third_word never accepted, expected acceptance after release");
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] d;
                    logic [7:0]  e;
                    d = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                    e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
                    drive(d, e, model(d, e));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int base;
        bus.out_ready = 1'b0;
        drive(32'h0000_0100, 8'd50, model(32'h0000_0100, 8'd50));
        drive(32'h0000_0200, 8'd50, model(32'h0000_0200, 8'd50));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_checks = n_checks + 1;
        if (bus.out_valid !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_mid_valid got %b, expected 0 immediately", bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        base = n_out;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks = n_checks + 1;
            if (bus.out_valid !== 1'b0) begin
                n_errors = n_errors + 1;
                $display("FAIL reset_idle cycle%0d out_valid=%b, expected 0", c, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        drive(32'h0000_8000, 8'd30, model(32'h0000_8000, 8'd30));
        @(negedge clk);
        @(negedge clk);
        n_checks = n_checks + 1;
        if (bus.out_valid !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_resume out_valid=%b two cycles after transfer, expected 1", bus.out_valid);
        end
        repeat (5) @(negedge clk);
        n_checks = n_checks + 1;
        if (n_out - base != 1) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_result_count got %0d results, expected 1", n_out - base);
        end
        wait_drain();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_out    = 0;
        mon_en   = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
